ctxt_word_packer: RTL and testbench
===================================

Name: ctxt_word_packer

Overview:
- Downstream stage of aes_sbox_stream_cipher.
- Collects the cipher's byte stream (txt_out_char qualified by dout_ready) and packs it into 32-bit words.
- Buffers the words in a small FIFO and presents them on a valid/ready interface to the file/bus writer.
- The cipher cannot be stalled, so the block never backpressures the byte side. Lost words are flagged rather than blocking.

Parameters:
DEPTH  4  word FIFO depth in words; power of 2, minimum 2
LW  $clog2(DEPTH)+1  width of fifo_level (derived, not overridable)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
byte_valid  input  1  byte strobe; connect to cipher dout_ready
byte_in  input  8  byte data; connect to cipher txt_out_char
flush  input  1  1-cycle pulse: emit partially filled word
word_out  output  32  packed word, lane0 = bits 7:0 = oldest byte
word_keep  output  4  lane-valid mask for word_out
word_valid  output  1  word_out/word_keep valid
word_ready  input  1  consumer accepts word when word_valid && word_ready
fifo_level  output  LW  number of words currently stored
overflow  output  1  sticky: a completed word was dropped because FIFO full

Behaviour:
- Reset (asynchronous, immediate on rst_n low):
  - word_out=0, word_keep=0, word_valid=0, fifo_level=0, overflow=0.
  - Assembly register and byte counter byte_cnt (0..3) cleared.
  - FIFO pointers cleared; any partial or stored data is discarded.
  - A reset asserted mid-word discards the partial word; no word is emitted for it.
- Byte capture:
  - On a rising edge with byte_valid=1, byte_in is written to lane byte_cnt and byte_cnt increments.
  - byte_valid is never ignored. There is no ready output on the byte side.
- Word completion:
  - When a byte is accepted with byte_cnt=3, the completed word (keep=4'b1111) is pushed into the FIFO on that same edge.
  - byte_cnt wraps to 0.
- Flush:
  - The lane count n includes the byte accepted in the same cycle.
  - flush=1 with n=1..3: push a partial word with keep = lower n bits set (e.g. 4'b0011). Unused lanes are 0. byte_cnt goes to 0.
  - flush=1 on the same edge as a 4th byte: exactly one full word is pushed, with no extra empty word.
  - flush=1 with byte_cnt=0 and no byte: no effect.
- FIFO behaviour (first-word-fall-through):
  - word_out, word_keep and word_valid are driven directly from the FIFO head.
  - Latency: a word pushed at edge k into an empty FIFO gives word_valid=1 in the cycle after edge k.
  - Pop occurs on an edge where word_valid && word_ready. The next word, if any, is visible in the following cycle.
  - When word_valid=0, word_out and word_keep read as 0.
  - word_ready while empty: no effect.
  - Simultaneous push and pop when full: allowed. The pop frees the slot, the push is accepted, fifo_level stays DEPTH, and overflow is unaffected.
  - Simultaneous push and pop when not full: fifo_level is unchanged.
- Overflow:
  - A push while full without a simultaneous pop drops the new word.
  - FIFO contents are unchanged; overflow is set and stays 1 until reset.
  - byte_cnt still returns to 0, so the next byte starts a fresh word.
- fifo_level ranges 0..DEPTH and is updated on the same edge as push/pop.
- Pointers wrap modulo DEPTH and use an extra MSB to tell full from empty.

Test Plan:
- Word packing: word_ready=1, bytes 11,22,33,44,55,66,77,88 on consecutive cycles -> words 32'h44332211 then 32'h88776655, keep 4'hF. Each word_valid rises 1 cycle after its 4th byte.
- Partial flush: bytes AA,BB,CC, then flush alone -> word 32'h00CCBBAA, keep 4'b0111. A following byte DD starts a new word in lane0.
- Flush coincident with bytes: flush together with the 4th byte -> one full word, keep F, no empty word. Flush together with the 1st byte EE -> word 32'h000000EE, keep 4'b0001.
- Overflow: DEPTH=4, word_ready=0, 20 bytes 00..13 -> fifo_level=4, overflow=1. Draining yields only 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C. overflow remains 1.
- Full push and pop together: fifo_level=4, word_ready=1 on the edge of a 4th byte -> level stays 4, overflow stays 0, and the new word appears last in order.
- Reset mid-operation: 2 bytes assembled plus 2 words stored, then rst_n low for 1 cycle -> word_valid=0 and fifo_level=0 immediately. A subsequent flush emits nothing. The next 4 bytes form a clean word.

Source files
------------

// File: rtl/ctxt_word_packer.sv
// Packs the cipher byte stream into 32-bit words and buffers them in a
// first-word-fall-through FIFO; words arriving while full are dropped and flagged.
module ctxt_word_packer #(
   parameter  int DEPTH = 4,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          byte_valid,
   input  logic [7:0]    byte_in,
   input  logic          flush,
   output logic [31:0]   word_out,
   output logic [3:0]    word_keep,
   output logic          word_valid,
   input  logic          word_ready,
   output logic [LW-1:0] fifo_level,
   output logic          overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [23:0]   asm_q, asm_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [LW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] rd_ptr_q, rd_ptr_d;
   logic          overflow_q, overflow_d;
   logic [35:0]   mem_q [DEPTH];

   logic [31:0]   lanes;
   logic [3:0]    keep;
   logic [2:0]    nLanes;
   logic          push, pop, full, empty, wrEn;
   logic [LW-1:0] level;
   logic [35:0]   head;

   // Lanes at or above cnt_q in asm_q are always zero, so inserting the
   // current byte yields a word whose unused lanes are already clear.
   always_comb begin
      lanes  = {8'h00, asm_q};
      keep   = 4'b0000;
      nLanes = {1'b0, cnt_q} + {2'b00, byte_valid};
      if (byte_valid) begin
         lanes[{cnt_q, 3'b000} +: 8] = byte_in;
      end
      case (nLanes)
         3'd1:    keep = 4'b0001;
         3'd2:    keep = 4'b0011;
         3'd3:    keep = 4'b0111;
         3'd4:    keep = 4'b1111;
         default: keep = 4'b0000;
      endcase
      push  = (nLanes == 3'd4) || (flush && (nLanes != 3'd0));
      asm_d = asm_q;
      cnt_d = cnt_q;
      if (push) begin
         asm_d = '0;
         cnt_d = '0;
      end else if (byte_valid) begin
         asm_d = lanes[23:0];
         cnt_d = cnt_q + 2'd1;
      end
   end

   // A pop on the same edge frees the head slot, so a push while full is
   // still accepted in that case.
   always_comb begin
      level      = wr_ptr_q - rd_ptr_q;
      full       = (level == LW'(DEPTH));
      empty      = (wr_ptr_q == rd_ptr_q);
      pop        = !empty && word_ready;
      wrEn       = push && (!full || pop);
      wr_ptr_d   = wrEn ? wr_ptr_q + LW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + LW'(1) : rd_ptr_q;
      overflow_d = overflow_q | (push && full && !pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_q      <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         asm_q      <= asm_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {keep, lanes};
      end
   end

   always_comb begin
      head       = mem_q[rd_ptr_q[AW-1:0]];
      word_valid = !empty;
      word_out   = word_valid ? head[31:0]  : 32'h0;
      word_keep  = word_valid ? head[35:32] : 4'h0;
      fifo_level = level;
      overflow   = overflow_q;
   end

endmodule

// File: tb/tb_ctxt_word_packer.sv
// Directed bench for ctxt_word_packer: expected words are queued when stimulus
// is driven and compared against each accepted word_valid/word_ready handshake.
module tb_ctxt_word_packer;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic          byte_valid;
   logic [7:0]    byte_in;
   logic          flush;
   logic [31:0]   word_out;
   logic [3:0]    word_keep;
   logic          word_valid;
   logic          word_ready;
   logic [LW-1:0] fifo_level;
   logic          overflow;

   int compared   = 0;
   int mismatched = 0;
   logic [35:0] sb[$];

   ctxt_word_packer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .byte_valid (byte_valid),
      .byte_in    (byte_in),
      .flush      (flush),
      .word_out   (word_out),
      .word_keep  (word_keep),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of byte-side inputs; entered and left at posedge+1.
   task automatic applyStimulus(input logic v, input logic [7:0] b, input logic f);
      byte_valid = v;
      byte_in    = b;
      flush      = f;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      flush      = 1'b0;
   endtask

   task automatic expectWord(input logic [31:0] w, input logic [3:0] k);
      sb.push_back({k, w});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
   endtask

   // Scoreboard side: each handshake seen at the falling edge pops on the next rising edge.
   always @(negedge clk) begin
      logic [35:0] e;
      if (rst_n && word_valid && word_ready) begin
         compared++;
         assert (sb.size() != 0) else begin
            mismatched++;
            $error("[TB] FAIL unexpected_word observed=%h/%h expected=none", word_out, word_keep);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("sb_word", word_out, e[31:0]);
            checkOutput("sb_keep", {28'h0, word_keep}, {28'h0, e[35:32]});
         end
      end
      if (rst_n && !word_valid) begin
         checkOutput("idle_word_zero", {word_out[31:4], word_out[3:0] | word_keep}, 32'h0);
      end
   end

   initial begin
      rst_n      = 1'b0;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      flush      = 1'b0;
      word_ready = 1'b0;
      #1;
      checkOutput("rst_word_out", word_out, 32'h0);
      checkOutput("rst_word_keep", {28'h0, word_keep}, 32'h0);
      checkOutput("rst_word_valid", {31'h0, word_valid}, 32'h0);
      checkOutput("rst_fifo_level", 32'(fifo_level), 32'h0);
      checkOutput("rst_overflow", {31'h0, overflow}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Full-word packing with a consumer that is always ready
      word_ready = 1'b1;
      expectWord(32'h44332211, 4'hF);
      expectWord(32'h88776655, 4'hF);
      applyStimulus(1'b1, 8'h11, 1'b0);
      applyStimulus(1'b1, 8'h22, 1'b0);
      applyStimulus(1'b1, 8'h33, 1'b0);
      checkOutput("pack_valid_before_4th", {31'h0, word_valid}, 32'h0);
      applyStimulus(1'b1, 8'h44, 1'b0);
      checkOutput("pack_valid_after_4th", {31'h0, word_valid}, 32'h1);
      checkOutput("pack_word0_head", word_out, 32'h44332211);
      applyStimulus(1'b1, 8'h55, 1'b0);
      applyStimulus(1'b1, 8'h66, 1'b0);
      applyStimulus(1'b1, 8'h77, 1'b0);
      applyStimulus(1'b1, 8'h88, 1'b0);
      checkOutput("pack_valid_after_8th", {31'h0, word_valid}, 32'h1);
      idle(1);
      checkOutput("pack_level_drained", 32'(fifo_level), 32'h0);

      // Partial flush, then a new word starting in lane0
      expectWord(32'h00CCBBAA, 4'b0111);
      expectWord(32'h000000DD, 4'b0001);
      applyStimulus(1'b1, 8'hAA, 1'b0);
      applyStimulus(1'b1, 8'hBB, 1'b0);
      applyStimulus(1'b1, 8'hCC, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("flush_partial_head", word_out, 32'h00CCBBAA);
      applyStimulus(1'b1, 8'hDD, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      idle(2);

      // Flush coinciding with the 4th byte and with a 1st byte; flush on empty
      expectWord(32'h04030201, 4'hF);
      applyStimulus(1'b1, 8'h01, 1'b0);
      applyStimulus(1'b1, 8'h02, 1'b0);
      applyStimulus(1'b1, 8'h03, 1'b0);
      applyStimulus(1'b1, 8'h04, 1'b1);
      idle(3);
      checkOutput("flush4_no_extra_level", 32'(fifo_level), 32'h0);
      expectWord(32'h000000EE, 4'b0001);
      applyStimulus(1'b1, 8'hEE, 1'b1);
      idle(1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      idle(2);
      checkOutput("flush_empty_level", 32'(fifo_level), 32'h0);

      // Overflow: 20 bytes into a stalled FIFO keep only the first four words
      word_ready = 1'b0;
      expectWord(32'h03020100, 4'hF);
      expectWord(32'h07060504, 4'hF);
      expectWord(32'h0B0A0908, 4'hF);
      expectWord(32'h0F0E0D0C, 4'hF);
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(i), 1'b0);
      checkOutput("ovf_level_full", 32'(fifo_level), 32'd4);
      checkOutput("ovf_flag_set", {31'h0, overflow}, 32'h1);
      word_ready = 1'b1;
      idle(5);
      checkOutput("ovf_level_drained", 32'(fifo_level), 32'h0);
      checkOutput("ovf_flag_sticky", {31'h0, overflow}, 32'h1);
      checkOutput("ovf_sb_empty", 32'(sb.size()), 32'h0);

      // Reset mid-operation discards the partial word and stored words
      word_ready = 1'b0;
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h50 + 8'(i), 1'b0);
      checkOutput("rstmid_level_before", 32'(fifo_level), 32'd2);
      rst_n = 1'b0;
      #1;
      checkOutput("rstmid_valid", {31'h0, word_valid}, 32'h0);
      checkOutput("rstmid_level", 32'(fifo_level), 32'h0);
      checkOutput("rstmid_overflow", {31'h0, overflow}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b1);
      idle(1);
      checkOutput("rstmid_flush_nothing", 32'(fifo_level), 32'h0);
      expectWord(32'hA4A3A2A1, 4'hF);
      applyStimulus(1'b1, 8'hA1, 1'b0);
      applyStimulus(1'b1, 8'hA2, 1'b0);
      applyStimulus(1'b1, 8'hA3, 1'b0);
      applyStimulus(1'b1, 8'hA4, 1'b0);
      checkOutput("rstmid_clean_word", word_out, 32'hA4A3A2A1);
      checkOutput("rstmid_clean_keep", {28'h0, word_keep}, 32'hF);

      // Simultaneous push and pop while full
      expectWord(32'hB3B2B1B0, 4'hF);
      expectWord(32'hB7B6B5B4, 4'hF);
      expectWord(32'hBBBAB9B8, 4'hF);
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 8'hB0 + 8'(i), 1'b0);
      checkOutput("pp_level_full", 32'(fifo_level), 32'd4);
      expectWord(32'hC3C2C1C0, 4'hF);
      applyStimulus(1'b1, 8'hC0, 1'b0);
      applyStimulus(1'b1, 8'hC1, 1'b0);
      applyStimulus(1'b1, 8'hC2, 1'b0);
      word_ready = 1'b1;
      applyStimulus(1'b1, 8'hC3, 1'b0);
      checkOutput("pp_level_stays", 32'(fifo_level), 32'd4);
      checkOutput("pp_overflow_clear", {31'h0, overflow}, 32'h0);
      idle(5);
      checkOutput("pp_level_drained", 32'(fifo_level), 32'h0);
      checkOutput("pp_sb_empty", 32'(sb.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
